mem_port_arbiter: RTL

- Shares the single multi-cycle memory port between the IF-stage instruction fetch and the MEM-stage data access of the pipelined RV32I core.
- Sits between the two pipeline memory interfaces and the cache/memory port.
- Serves one transaction at a time and registers the winner's request for its full duration.
- Data side has priority, bounded by a starvation guard for fetch.

---
 rtl/mem_port_arbiter_pkg.sv | 7 +
 rtl/rv32i_types.sv | 7 +
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// arb_types: state and operation encodings for the memory port arbiter
package arb_types;

    typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} arb_state_t;
    typedef enum logic {ARB_OP_READ, ARB_OP_WRITE} arb_op_t;

endpackage

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I word and byte-mask types
package rv32i_types;

    typedef logic [31:0] rv32i_word;
    typedef logic [3:0]  rv32i_mem_wmask;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory port between fetch and data, data first with a fetch starvation guard
module mem_port_arbiter
    import rv32i_types::*;
    import arb_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_read,
    input  rv32i_word      i_addr,
    output rv32i_word      i_rdata,
    output logic           i_resp,
    input  logic           d_read,
    input  logic           d_write,
    input  rv32i_word      d_addr,
    input  rv32i_word      d_wdata,
    input  rv32i_mem_wmask d_wmask,
    output rv32i_word      d_rdata,
    output logic           d_resp,
    output logic           m_read,
    output logic           m_write,
    output rv32i_word      m_addr,
    output rv32i_word      m_wdata,
    output rv32i_mem_wmask m_wmask,
    input  rv32i_word      m_rdata,
    input  logic           m_resp
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t     state, state_nxt;
    arb_op_t        op, op_nxt;
    rv32i_word      addr, addr_nxt, wdata, wdata_nxt;
    rv32i_mem_wmask wmask, wmask_nxt;
    logic [3:0]     starve_cnt, starve_nxt;
    logic           d_pend, i_pend, d_win, busy, is_wr;

    // Arbitration in IDLE and completion in SERVE_x; the winner's request is captured for the whole transaction
    always_comb begin
        state_nxt  = state;
        op_nxt     = op;
        addr_nxt   = addr;
        wdata_nxt  = wdata;
        wmask_nxt  = wmask;
        starve_nxt = starve_cnt;
        d_pend     = d_read | d_write;
        i_pend     = i_read;
        d_win      = d_pend && (!i_pend || starve_cnt < LIMIT);
        case (state)
            ARB_IDLE: begin
                if (d_win) begin
                    state_nxt = ARB_SERVE_D;
                    op_nxt    = d_write ? ARB_OP_WRITE : ARB_OP_READ;
                    addr_nxt  = d_addr;
                    wdata_nxt = d_wdata;
                    wmask_nxt = d_wmask;
                    if (i_pend && starve_cnt < LIMIT) starve_nxt = starve_cnt + 4'd1;
                end else if (i_pend) begin
                    state_nxt  = ARB_SERVE_I;
                    op_nxt     = ARB_OP_READ;
                    addr_nxt   = i_addr;
                    wdata_nxt  = '0;
                    wmask_nxt  = '0;
                    starve_nxt = '0;
                end
            end
            default: if (m_resp) state_nxt = ARB_IDLE;
        endcase
    end

    // State, captured request and starvation counter; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            op         <= ARB_OP_READ;
            addr       <= '0;
            wdata      <= '0;
            wmask      <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            op         <= op_nxt;
            addr       <= addr_nxt;
            wdata      <= wdata_nxt;
            wmask      <= wmask_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Memory side driven only from registered state, so requester inputs never reach m_* combinationally
    always_comb begin
        busy    = state != ARB_IDLE;
        is_wr   = op == ARB_OP_WRITE;
        m_read  = busy && !is_wr;
        m_write = busy && is_wr;
        m_addr  = busy ? addr : '0;
        m_wdata = m_write ? wdata : '0;
        m_wmask = m_write ? wmask : '0;
        i_resp  = state == ARB_SERVE_I && m_resp;
        d_resp  = state == ARB_SERVE_D && m_resp;
        i_rdata = m_rdata;
        d_rdata = m_rdata;
    end

endmodule
